// File: rtl/fc_input_packer_pkg.sv
`default_nettype none
// ============================================================================
// fc_input_packer_pkg
// Constants shared between the input packer and the classifier top, plus the
// packer state encoding.
// Revision: 1.0
// ============================================================================
package fc_input_packer_pkg;

    localparam int DATA_WIDTH  = 32;
    localparam int INPUT_NODES = 400;
    // One classifier pass takes INPUT_NODES + 3 cycles
    localparam int HOLD_CYCLES = INPUT_NODES + 3;

    localparam logic [1:0] c_ST_FILL   = 2'd0;
    localparam logic [1:0] c_ST_DRAIN  = 2'd1;
    localparam logic [1:0] c_ST_LAUNCH = 2'd2;
    localparam logic [1:0] c_ST_HOLD   = 2'd3;

    typedef enum logic [1:0] {
        ST_FILL   = c_ST_FILL,
        ST_DRAIN  = c_ST_DRAIN,
        ST_LAUNCH = c_ST_LAUNCH,
        ST_HOLD   = c_ST_HOLD
    } state_e;

endpackage : fc_input_packer_pkg
`default_nettype wire

// File: rtl/fc_input_packer.sv
`default_nettype none
// ============================================================================
// fc_input_packer
// Packs a stream of feature words into one wide classifier input vector,
// pulses the classifier reset and holds the vector for a full pass.
// Revision: 1.0
// ============================================================================
module fc_input_packer
    import fc_input_packer_pkg::*;
#(
    parameter int DATA_WIDTH  = fc_input_packer_pkg::DATA_WIDTH,
    parameter int INPUT_NODES = fc_input_packer_pkg::INPUT_NODES,
    parameter int HOLD_CYCLES = fc_input_packer_pkg::HOLD_CYCLES
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [DATA_WIDTH-1:0]             s_data,
    input  logic                              s_valid,
    input  logic                              s_last,
    output logic                              s_ready,
    output logic [DATA_WIDTH*INPUT_NODES-1:0] vec_out,
    output logic                              ann_reset,
    output logic                              vec_valid,
    output logic                              frame_err
);

    localparam int c_IDX_W  = (INPUT_NODES > 1) ? $clog2(INPUT_NODES) : 1;
    localparam int c_HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [c_IDX_W-1:0]  c_LAST_IDX  = c_IDX_W'(INPUT_NODES - 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_LOAD = c_HOLD_W'(HOLD_CYCLES - 1);

    state_e                r_state_q, w_state_d;
    logic [c_IDX_W-1:0]    r_idx_q, w_idx_d;
    logic [c_HOLD_W-1:0]   r_hold_q, w_hold_d;
    logic                  r_frame_err_q, w_frame_err_d;
    logic                  w_fill_we;
    logic [INPUT_NODES-1:0] w_word_we;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state_q     <= ST_FILL;
            r_idx_q       <= '0;
            r_hold_q      <= '0;
            r_frame_err_q <= 1'b0;
        end else begin
            r_state_q     <= w_state_d;
            r_idx_q       <= w_idx_d;
            r_hold_q      <= w_hold_d;
            r_frame_err_q <= w_frame_err_d;
        end
    end

    always_comb begin
        w_state_d     = r_state_q;
        w_idx_d       = r_idx_q;
        w_hold_d      = r_hold_q;
        w_frame_err_d = 1'b0;
        w_fill_we     = 1'b0;
        case (r_state_q)
            ST_FILL: begin
                if (s_valid) begin
                    w_fill_we = 1'b1;
                    if (r_idx_q == c_LAST_IDX) begin
                        // Index is cleared here so DRAIN and LAUNCH both leave it at 0
                        w_idx_d = '0;
                        if (s_last) begin
                            w_state_d = ST_LAUNCH;
                        end else begin
                            w_frame_err_d = 1'b1;
                            w_state_d     = ST_DRAIN;
                        end
                    end else if (s_last) begin
                        w_frame_err_d = 1'b1;
                        w_idx_d       = '0;
                    end else begin
                        w_idx_d = r_idx_q + 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (s_valid && s_last) begin
                    w_state_d = ST_FILL;
                    w_idx_d   = '0;
                end
            end
            ST_LAUNCH: begin
                w_hold_d  = c_HOLD_LOAD;
                w_state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (r_hold_q == '0) begin
                    w_state_d = ST_FILL;
                    w_idx_d   = '0;
                end else begin
                    w_hold_d = r_hold_q - 1'b1;
                end
            end
            default: begin
                w_state_d = ST_FILL;
                w_idx_d   = '0;
            end
        endcase
    end

    // Each word slot has its own register, enabled one-hot by the fill index
    generate
        for (genvar i = 0; i < INPUT_NODES; i++) begin : g_word
            localparam logic [c_IDX_W-1:0] c_SLOT = c_IDX_W'(i);
            logic [DATA_WIDTH-1:0] r_word_q;

            assign w_word_we[i] = w_fill_we && (r_idx_q == c_SLOT);

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_word_q <= '0;
                end else if (w_word_we[i]) begin
                    r_word_q <= s_data;
                end
            end

            assign vec_out[DATA_WIDTH*i +: DATA_WIDTH] = r_word_q;
        end
    endgenerate

    assign s_ready   = (r_state_q == ST_FILL) || (r_state_q == ST_DRAIN);
    assign ann_reset = (r_state_q == ST_LAUNCH);
    assign vec_valid = (r_state_q == ST_LAUNCH) || (r_state_q == ST_HOLD);
    assign frame_err = r_frame_err_q;

endmodule : fc_input_packer
`default_nettype wire

// File: tb/tb_fc_input_packer.sv
`default_nettype none
// ============================================================================
// tb_fc_input_packer
// Scoreboard bench: expected launch/error events queued by stimulus, popped
// and compared by a monitor whenever the packer emits ann_reset or frame_err.
// Revision: 1.0
// ============================================================================
module tb_fc_input_packer;

    localparam int c_DW    = 32;
    localparam int c_N     = 400;
    localparam int c_HOLD  = 403;
    localparam int c_VEC_W = c_DW * c_N;

    typedef struct packed {
        logic               launch;
        logic [c_VEC_W-1:0] vec;
    } exp_t;

    logic               clk;
    logic               reset;
    logic [c_DW-1:0]    s_data;
    logic               s_valid;
    logic               s_last;
    logic               s_ready;
    logic [c_VEC_W-1:0] vec_out;
    logic               ann_reset;
    logic               vec_valid;
    logic               frame_err;

    exp_t q_exp[$];
    int   checks;
    int   errors;
    bit   mon_busy;

    fc_input_packer #(
        .DATA_WIDTH  (c_DW),
        .INPUT_NODES (c_N),
        .HOLD_CYCLES (c_HOLD)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_last    (s_last),
        .s_ready   (s_ready),
        .vec_out   (vec_out),
        .ann_reset (ann_reset),
        .vec_valid (vec_valid),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [c_VEC_W-1:0] build_vec(input int base);
        logic [c_VEC_W-1:0] v;
        v = '0;
        for (int k = 0; k < c_N; k++) v[c_DW*k +: c_DW] = 32'(base + k + 1);
        return v;
    endfunction

    // Caller is at a negedge; returns at a negedge after the word is accepted
    task automatic send_word(input logic [31:0] d, input logic last, input bit gap);
        int n;
        n       = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        while (!s_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout actual=%0d expected=<3000", n);
        end else begin
            @(posedge clk);
            @(negedge clk);
        end
        if (gap) begin
            s_valid = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic send_frame(input int base, input int len, input bit gap);
        for (int k = 0; k < len; k++) send_word(32'(base + k + 1), (k == len - 1), gap);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    // Monitor: pops one expected event per ann_reset / frame_err pulse
    initial begin
        exp_t               e;
        logic [c_VEC_W-1:0] held;
        bit                 hold_ok;
        mon_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset && (ann_reset || frame_err)) begin
                mon_busy = 1'b1;
                if (q_exp.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_event actual=ann%0b/err%0b expected=none", ann_reset, frame_err);
                end else begin
                    e = q_exp.pop_front();
                    chk("event_is_launch", {63'd0, ann_reset}, {63'd0, e.launch});
                    chk("event_is_err", {63'd0, frame_err}, {63'd0, ~e.launch});
                    if (ann_reset) begin
                        checks++;
                        if (vec_out !== e.vec) begin
                            errors++;
                            for (int k = 0; k < c_N; k++) begin
                                if (vec_out[c_DW*k +: c_DW] !== e.vec[c_DW*k +: c_DW]) begin
                                    $display("FAIL vec_word%0d actual=%0h expected=%0h", k,
                                             vec_out[c_DW*k +: c_DW], e.vec[c_DW*k +: c_DW]);
                                    break;
                                end
                            end
                        end
                        chk("launch_vec_valid", {63'd0, vec_valid}, 64'd1);
                        chk("launch_s_ready", {63'd0, s_ready}, 64'd0);
                        held    = vec_out;
                        hold_ok = 1'b1;
                        for (int c = 0; c < c_HOLD; c++) begin
                            @(negedge clk);
                            if (!vec_valid || s_ready || ann_reset || vec_out !== held) begin
                                if (hold_ok)
                                    $display("FAIL hold_cycle%0d actual=vv%0b rdy%0b ann%0b expected=vv1 rdy0 ann0 stable",
                                             c, vec_valid, s_ready, ann_reset);
                                hold_ok = 1'b0;
                            end
                        end
                        chk("hold_stable_403", {63'd0, hold_ok}, 64'd1);
                        @(negedge clk);
                        chk("post_hold_vec_valid", {63'd0, vec_valid}, 64'd0);
                        chk("post_hold_s_ready", {63'd0, s_ready}, 64'd1);
                    end
                end
                mon_busy = 1'b0;
            end
        end
    end

    initial begin
        exp_t e;
        int   n;
        checks  = 0;
        errors  = 0;
        reset   = 1'b1;
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = '0;
        repeat (3) @(negedge clk);
        chk("rst_s_ready", {63'd0, s_ready}, 64'd1);
        chk("rst_ann_reset", {63'd0, ann_reset}, 64'd0);
        chk("rst_vec_valid", {63'd0, vec_valid}, 64'd0);
        chk("rst_frame_err", {63'd0, frame_err}, 64'd0);
        chk("rst_vec_zero", {63'd0, (vec_out == '0)}, 64'd1);
        reset = 1'b0;
        @(negedge clk);

        // Reset in the middle of a frame
        for (int k = 0; k < 50; k++) send_word(32'(k + 77), 1'b0, 1'b0);
        s_valid = 1'b0;
        chk("midrun_word0_written", {32'd0, vec_out[31:0]}, 64'd77);
        reset = 1'b1;
        #1;
        chk("midrun_rst_vec_zero", {63'd0, (vec_out == '0)}, 64'd1);
        chk("midrun_rst_s_ready", {63'd0, s_ready}, 64'd1);
        chk("midrun_rst_vec_valid", {63'd0, vec_valid}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Nominal frame (values k+1), then next frame offered during HOLD
        e.launch = 1'b1; e.vec = build_vec(0);    q_exp.push_back(e);
        send_frame(0, c_N, 1'b0);
        e.launch = 1'b1; e.vec = build_vec(1000); q_exp.push_back(e);
        send_frame(1000, c_N, 1'b0);

        // Short frame then a full frame
        e.launch = 1'b0; e.vec = '0;              q_exp.push_back(e);
        send_frame(500, 10, 1'b0);
        e.launch = 1'b1; e.vec = build_vec(2000); q_exp.push_back(e);
        send_frame(2000, c_N, 1'b0);

        // Long frame then a full frame
        e.launch = 1'b0; e.vec = '0;              q_exp.push_back(e);
        send_frame(9000, c_N + 5, 1'b0);
        e.launch = 1'b1; e.vec = build_vec(3000); q_exp.push_back(e);
        send_frame(3000, c_N, 1'b0);

        // Gapped input
        e.launch = 1'b1; e.vec = build_vec(4000); q_exp.push_back(e);
        send_frame(4000, c_N, 1'b1);

        n = 0;
        while ((q_exp.size() != 0 || mon_busy) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        repeat (5) @(negedge clk);
        chk("scoreboard_drained", 64'(q_exp.size()), 64'd0);
        chk("monitor_idle", {63'd0, mon_busy}, 64'd0);
        chk("final_word0", {32'd0, vec_out[31:0]}, 64'd4001);
        chk("final_word399", {32'd0, vec_out[12799:12768]}, 64'd4400);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_fc_input_packer
`default_nettype wire
